usb_tx_packet_serializer: RTL and testbench

//  Turns one outgoing USB packet (PID + optional payload bytes) into a serial bit stream, LSB-first per byte.

---
 rtl/usb_tx_packet_serializer.sv | 187 ++++++++++++++++++
 tb/tb_usb_tx_packet_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packet_serializer.sv
// USB TX packet serializer: PID, optional payload and inverted CRC16, sent LSB-first per byte.
// Bits are paced by the downstream tx_ready. Underrun or overlength aborts the packet.

module usb_crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid_i,
    input  logic        data_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q, crc_d;
    logic        fb;

    // Polynomial x^16+x^15+x^2+1, with the register shifting toward its MSB.
    always_comb begin
        fb    = crc_q[15] ^ data_i;
        crc_d = crc_q;
        if (data_valid_i) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= 16'hFFFF;
        else     crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

module usb_tx_packet_serializer #(
    parameter int MAX_BYTES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic       has_data,
    input  logic       has_crc,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_eop,
    output logic       busy,
    output logic       abort,
    output logic [9:0] byte_count
);
    typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_CRC} state_t;

    localparam logic [10:0] MAX_W = 11'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [9:0]  byte_count_q, byte_count_d;
    logic        has_data_q, has_data_d;
    logic        has_crc_q, has_crc_d;
    logic        last_q, last_d;
    logic        crc_init_q, crc_init_d;
    logic        accept, byte_done, fetch, over_limit;
    logic [15:0] crc_result;

    assign accept     = tx_valid & tx_ready;
    assign byte_done  = accept && (bit_idx_q[2:0] == 3'd7);
    assign over_limit = ({1'b0, byte_count_q} + 11'd1) > MAX_W;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        byte_count_d = byte_count_q;
        has_data_d   = has_data_q;
        has_crc_d    = has_crc_q;
        last_d       = last_q;
        crc_init_d   = 1'b0;
        fetch        = 1'b0;
        in_ready     = 1'b0;
        tx_eop       = 1'b0;
        abort        = 1'b0;
        tx_valid     = (state_q != S_IDLE);
        tx_bit       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d      = {~pid, pid};
                    has_data_d   = has_data;
                    has_crc_d    = has_crc;
                    last_d       = 1'b0;
                    byte_count_d = '0;
                    bit_idx_d    = '0;
                    crc_init_d   = 1'b1;
                    state_d      = S_PID;
                end
            end
            S_PID: begin
                tx_bit = shift_q[bit_idx_q[2:0]];
                if (accept) bit_idx_d = bit_idx_q + 4'd1;
                if (byte_done) begin
                    bit_idx_d = '0;
                    if (has_data_q) begin
                        fetch = 1'b1;
                    end else if (has_crc_q) begin
                        state_d = S_CRC;
                    end else begin
                        tx_eop  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                tx_bit = shift_q[bit_idx_q[2:0]];
                if (accept) bit_idx_d = bit_idx_q + 4'd1;
                if (byte_done) begin
                    bit_idx_d = '0;
                    if (last_q) state_d = S_CRC;
                    else        fetch   = 1'b1;
                end
            end
            S_CRC: begin
                // CRC field goes out MSB of the register first, inverted.
                tx_bit = ~crc_result[4'd15 - bit_idx_q];
                if (accept) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd15) begin
                        tx_eop  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fetch) begin
            if (in_valid && !over_limit) begin
                in_ready     = 1'b1;
                shift_d      = in_data;
                last_d       = in_last;
                byte_count_d = byte_count_q + 10'd1;
                state_d      = S_DATA;
            end else begin
                abort   = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            byte_count_q <= '0;
            has_data_q   <= 1'b0;
            has_crc_q    <= 1'b0;
            last_q       <= 1'b0;
            crc_init_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            byte_count_q <= byte_count_d;
            has_data_q   <= has_data_d;
            has_crc_q    <= has_crc_d;
            last_q       <= last_d;
            crc_init_q   <= crc_init_d;
        end
    end

    logic crc_rst;
    assign crc_rst = rst | crc_init_q;

    usb_crc16 u_crc (
        .clk          (clk),
        .rst          (crc_rst),
        .data_valid_i ((state_q == S_DATA) && accept),
        .data_i       (tx_bit),
        .crc_o        (crc_result)
    );

    assign busy       = (state_q != S_IDLE);
    assign byte_count = byte_count_q;
endmodule

// File: tb/tb_usb_tx_packet_serializer.sv
// Directed bench for usb_tx_packet_serializer: handshake, CRC-only, payload, stalls,
// underrun, overlength and mid-packet reset, checked against a bytewise reflected CRC16 model.

module tb_usb_tx_packet_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pid = 4'h0;
    logic       has_data = 1'b0;
    logic       has_crc = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_eop;
    logic       busy;
    logic       abort;
    logic [9:0] byte_count;

    int total = 0;
    int bad = 0;

    logic got_bits[$];
    logic exp_bits[$];
    logic first_valid;
    int   eop_cnt, eop_pos, abort_cnt, abort_pos, stall_viol;
    bit   timed_out;

    always #5 clk = ~clk;

    usb_tx_packet_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pid        (pid),
        .has_data   (has_data),
        .has_crc    (has_crc),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_eop     (tx_eop),
        .busy       (busy),
        .abort      (abort),
        .byte_count (byte_count)
    );

    // Expected stream: PID byte, payload bytes i[7:0], then inverted CRC16 (reflected form, low bit first).
    task automatic build_exp(input logic [3:0] p, input int nb, input bit crc_field);
        logic [7:0]  b;
        logic [15:0] r;
        exp_bits.delete();
        b = {~p, p};
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        r = 16'hFFFF;
        for (int j = 0; j < nb; j++) begin
            b = 8'(j);
            for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
            r = r ^ {8'h00, b};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        if (crc_field) begin
            r = ~r;
            for (int i = 0; i < 16; i++) exp_bits.push_back(r[i]);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
        for (int i = 0; i < n; i++) if (got_bits[i] !== exp_bits[i]) return i;
        if (got_bits.size() != exp_bits.size()) return n;
        return -1;
    endfunction

    // Runs one packet: payload byte i is i[7:0]; byte under_idx is withheld (in_valid low).
    task automatic run_pkt(input logic [3:0] p, input logic hd, input logic hc, input int nb,
                           input int under_idx, input int pct_low, input bit poke_start);
        int   idx;
        int   cyc;
        bit   done;
        bit   prev_stall;
        logic prev_bit;
        idx = 0; cyc = 0; done = 0; prev_stall = 0; prev_bit = 1'b0;
        got_bits.delete();
        eop_cnt = 0; eop_pos = -1; abort_cnt = 0; abort_pos = -1; stall_viol = 0;
        @(negedge clk);
        pid = p; has_data = hd; has_crc = hc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; pid = 4'h0; has_data = 1'b0; has_crc = 1'b0;
        first_valid = tx_valid;
        while (!done && cyc < 12000) begin
            tx_ready = ($urandom_range(99) < pct_low) ? 1'b0 : 1'b1;
            in_valid = (idx < nb) && (idx != under_idx);
            in_data  = 8'(idx);
            in_last  = (idx == nb - 1);
            start    = poke_start && (cyc == 5);
            #1;
            if (prev_stall && tx_valid && (tx_bit !== prev_bit)) stall_viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_bit   = tx_bit;
            if (tx_valid && tx_ready) got_bits.push_back(tx_bit);
            if (tx_eop) begin eop_cnt++; eop_pos = got_bits.size(); done = 1; end
            if (abort) begin abort_cnt++; abort_pos = got_bits.size(); done = 1; end
            if (in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        timed_out = !done;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b0;
        $display("pkt pid=%h bits=%0d eop=%0d abort=%0d byte_count=%0d stall_viol=%0d",
                 p, got_bits.size(), eop_cnt, abort_cnt, byte_count, stall_viol);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({tx_valid, tx_bit, in_ready, tx_eop, abort, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000", {tx_valid, tx_bit, in_ready, tx_eop, abort, busy});
        end
        total++;
        if (byte_count !== 10'd0) begin bad++; $display("FAIL reset_byte_count got=%0d want=0", byte_count); end
        rst = 1'b0;
    endtask

    task automatic test_handshake();
        run_pkt(4'h2, 1'b0, 1'b0, 0, -1, 0, 1'b0);
        build_exp(4'h2, 0, 1'b0);
        total++;
        if (timed_out || first_valid !== 1'b1) begin bad++; $display("FAIL ack_latency valid=%b timeout=%0d want valid=1", first_valid, timed_out); end
        total++;
        if (first_diff() != -1) begin bad++; $display("FAIL ack_bits diff_at=%0d got_len=%0d want_len=%0d", first_diff(), got_bits.size(), exp_bits.size()); end
        total++;
        if (eop_cnt != 1 || eop_pos != 8 || abort_cnt != 0) begin bad++; $display("FAIL ack_eop eop=%0d pos=%0d abort=%0d want 1/8/0", eop_cnt, eop_pos, abort_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ack_idle busy=%b want=0", busy); end
    endtask

    task automatic test_crc_only(input string tag);
        run_pkt(4'h3, 1'b0, 1'b1, 0, -1, 0, 1'b0);
        build_exp(4'h3, 0, 1'b1);
        total++;
        if (timed_out || first_diff() != -1) begin bad++; $display("FAIL %s_bits diff_at=%0d got_len=%0d want_len=24", tag, first_diff(), got_bits.size()); end
        total++;
        if (eop_cnt != 1 || eop_pos != 24 || abort_cnt != 0) begin bad++; $display("FAIL %s_eop eop=%0d pos=%0d abort=%0d want 1/24/0", tag, eop_cnt, eop_pos, abort_cnt); end
    endtask

    task automatic test_payload();
        run_pkt(4'hB, 1'b1, 1'b1, 4, -1, 0, 1'b1);
        build_exp(4'hB, 4, 1'b1);
        total++;
        if (timed_out || first_diff() != -1) begin bad++; $display("FAIL data1_bits diff_at=%0d got_len=%0d want_len=56", first_diff(), got_bits.size()); end
        total++;
        if (eop_cnt != 1 || eop_pos != 56 || abort_cnt != 0) begin bad++; $display("FAIL data1_eop eop=%0d pos=%0d abort=%0d want 1/56/0", eop_cnt, eop_pos, abort_cnt); end
        total++;
        if (byte_count !== 10'd4) begin bad++; $display("FAIL data1_byte_count got=%0d want=4", byte_count); end
    endtask

    task automatic test_ready_stall();
        run_pkt(4'hB, 1'b1, 1'b1, 4, -1, 30, 1'b0);
        build_exp(4'hB, 4, 1'b1);
        total++;
        if (timed_out || first_diff() != -1) begin bad++; $display("FAIL stall_bits diff_at=%0d got_len=%0d want_len=56", first_diff(), got_bits.size()); end
        total++;
        if (stall_viol != 0) begin bad++; $display("FAIL stall_hold changes=%0d want=0", stall_viol); end
        total++;
        if (eop_cnt != 1 || byte_count !== 10'd4) begin bad++; $display("FAIL stall_end eop=%0d byte_count=%0d want 1/4", eop_cnt, byte_count); end
    endtask

    task automatic test_underrun();
        run_pkt(4'hB, 1'b1, 1'b1, 3, 1, 0, 1'b0);
        build_exp(4'hB, 1, 1'b0);
        total++;
        if (timed_out || abort_cnt != 1 || abort_pos != 16 || eop_cnt != 0) begin
            bad++;
            $display("FAIL underrun_abort abort=%0d pos=%0d eop=%0d want 1/16/0", abort_cnt, abort_pos, eop_cnt);
        end
        total++;
        if (first_diff() != -1) begin bad++; $display("FAIL underrun_bits diff_at=%0d got_len=%0d want_len=16", first_diff(), got_bits.size()); end
        total++;
        if (byte_count !== 10'd1 || busy !== 1'b0) begin bad++; $display("FAIL underrun_state byte_count=%0d busy=%b want 1/0", byte_count, busy); end
    endtask

    task automatic test_overlength();
        run_pkt(4'h3, 1'b1, 1'b1, 1024, -1, 0, 1'b0);
        build_exp(4'h3, 1023, 1'b0);
        total++;
        if (timed_out || abort_cnt != 1 || abort_pos != 8192 || eop_cnt != 0) begin
            bad++;
            $display("FAIL overlen_abort abort=%0d pos=%0d eop=%0d want 1/8192/0", abort_cnt, abort_pos, eop_cnt);
        end
        total++;
        if (first_diff() != -1) begin bad++; $display("FAIL overlen_bits diff_at=%0d got_len=%0d want_len=8192", first_diff(), got_bits.size()); end
        total++;
        if (byte_count !== 10'd1023) begin bad++; $display("FAIL overlen_byte_count got=%0d want=1023", byte_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pid = 4'hB; has_data = 1'b1; has_crc = 1'b1; start = 1'b1;
        tx_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b0;
        @(negedge clk);
        start = 1'b0; has_data = 1'b0; has_crc = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (busy !== 1'b1 || byte_count !== 10'd1) begin bad++; $display("FAIL midrst_pre busy=%b byte_count=%0d want 1/1", busy, byte_count); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({tx_valid, tx_bit, in_ready, tx_eop, abort, busy} !== 6'b0 || byte_count !== 10'd0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b byte_count=%0d want 000000/0", {tx_valid, tx_bit, in_ready, tx_eop, abort, busy}, byte_count);
        end
        tx_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        test_crc_only("after_rst");
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_crc_only("data0");
        test_payload();
        test_ready_stall();
        test_underrun();
        test_overlength();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
